io_debounce: RTL and testbench

Input conditioning stage between the board pins and the core's `i_io_sw` / `i_io_btn` inputs. Synchronises the raw switch and key pins into `i_clk` and debounces the four push-buttons so the LSU's input registers see clean, glitch-free levels. Also provides a one-cycle press pulse per button for software-polling diagnostics.

---
 rtl/io_debounce.sv | 133 +++++++++++++
 tb/tb_io_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/io_debounce.sv
// Pin conditioning: 2-flop synchronisers, per-button STABLE/COUNT debouncers and press pulses.
// Define IO_SW_DEBOUNCE_EN to also debounce the 32 switch bits with the same filter.
//   state  | meaning
//   STABLE | synced input equals debounced level; counter held at 0
//   COUNT  | input differs; counting consecutive differing cycles up to DEB_CYCLES-1
module io_debounce #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_btn_raw,
    input  logic [31:0] i_sw_raw,
    output logic [3:0]  o_io_btn,
    output logic [31:0] o_io_sw,
    output logic [3:0]  o_btn_press
);

    localparam int NB = 4;
    localparam int NS = 32;

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_COUNT  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [0:0]       st;
        logic [CNT_W-1:0] cnt;
        logic             deb;
    } deb_t;

    localparam deb_t DEB_RST = '{st: ST_STABLE, cnt: '0, deb: 1'b0};

    function automatic deb_t deb_next(input deb_t cur, input logic s);
        deb_t nxt;
        nxt = cur;
        if (cur.st == ST_STABLE) begin
            if (s != cur.deb) begin
                nxt.st  = ST_COUNT;
                nxt.cnt = CNT_ONE;
            end else begin
                nxt.cnt = '0;
            end
        end else if (s == cur.deb) begin
            nxt.st  = ST_STABLE;
            nxt.cnt = '0;
        end else if (cur.cnt == CNT_LAST) begin
            nxt.st  = ST_STABLE;
            nxt.cnt = '0;
            nxt.deb = ~cur.deb;
        end else begin
            nxt.cnt = cur.cnt + CNT_ONE;
        end
        return nxt;
    endfunction

    // Idle pin levels: keys are active-low so they rest high, switches rest low.
    logic [NB-1:0] btn_meta_q, btn_sync_q;
    logic [NS-1:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= i_btn_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= i_sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    logic [NB-1:0] btn_s;
    assign btn_s = ~btn_sync_q;

    deb_t          btn_q [NB];
    deb_t          btn_d [NB];
    logic [NB-1:0] press_q, press_d;

    always_comb begin
        press_d = '0;
        for (int i = 0; i < NB; i++) begin
            btn_d[i]   = deb_next(btn_q[i], btn_s[i]);
            press_d[i] = btn_d[i].deb & ~btn_q[i].deb;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NB; i++) btn_q[i] <= DEB_RST;
            press_q <= '0;
        end else begin
            for (int i = 0; i < NB; i++) btn_q[i] <= btn_d[i];
            press_q <= press_d;
        end
    end

    always_comb begin
        o_io_btn = '0;
        for (int i = 0; i < NB; i++) o_io_btn[i] = btn_q[i].deb;
    end

    assign o_btn_press = press_q;

`ifdef IO_SW_DEBOUNCE_EN
    deb_t sw_q [NS];
    deb_t sw_d [NS];

    always_comb begin
        for (int i = 0; i < NS; i++) sw_d[i] = deb_next(sw_q[i], sw_sync_q[i]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NS; i++) sw_q[i] <= DEB_RST;
        end else begin
            for (int i = 0; i < NS; i++) sw_q[i] <= sw_d[i];
        end
    end

    always_comb begin
        o_io_sw = '0;
        for (int i = 0; i < NS; i++) o_io_sw[i] = sw_q[i].deb;
    end
`else
    assign o_io_sw = sw_sync_q;
`endif

endmodule

// File: tb/tb_io_debounce.sv
// Directed bench for io_debounce with DEB_CYCLES=4: press/bounce/release/simultaneous/switch/reset cases.
module tb_io_debounce;

    localparam int DEB = 4;
`ifdef IO_SW_DEBOUNCE_EN
    localparam int SW_LAT = 2 + DEB;
`else
    localparam int SW_LAT = 2;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_btn_raw;
    logic [31:0] i_sw_raw;
    logic [3:0]  o_io_btn;
    logic [31:0] o_io_sw;
    logic [3:0]  o_btn_press;

    int n_checks = 0;
    int n_pass   = 0;

    io_debounce #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_btn_raw   (i_btn_raw),
        .i_sw_raw    (i_sw_raw),
        .o_io_btn    (o_io_btn),
        .o_io_sw     (o_io_sw),
        .o_btn_press (o_btn_press)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_btn_raw = 4'hF;
        i_sw_raw  = 32'h0;
        tick();
        tick();
        n_checks++;
        if (o_io_btn !== 4'h0) $display("FAIL reset_btn: got %h want 0", o_io_btn);
        else n_pass++;
        n_checks++;
        if (o_io_sw !== 32'h0) $display("FAIL reset_sw: got %h want 0", o_io_sw);
        else n_pass++;
        n_checks++;
        if (o_btn_press !== 4'h0) $display("FAIL reset_press: got %h want 0", o_btn_press);
        else n_pass++;
        i_rst_n = 1'b1;
        settle();
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_btn, exp_press;
        i_btn_raw[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_btn   = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_press = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (o_io_btn !== exp_btn) $display("FAIL press_btn k=%0d: got %b want %b", k, o_io_btn, exp_btn);
            else n_pass++;
            n_checks++;
            if (o_btn_press !== exp_press) $display("FAIL press_pulse k=%0d: got %b want %b", k, o_btn_press, exp_press);
            else n_pass++;
        end
        i_btn_raw[0] = 1'b1;
        settle();
    endtask

    task automatic test_bounce();
        logic pattern [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 18; k++) begin
            i_btn_raw[1] = (k < 8) ? pattern[k] : 1'b1;
            tick();
            n_checks++;
            if (o_io_btn !== 4'h0 || o_btn_press !== 4'h0)
                $display("FAIL bounce k=%0d: btn=%b press=%b want 0/0", k, o_io_btn, o_btn_press);
            else n_pass++;
        end
    endtask

    task automatic test_release();
        logic [3:0] exp_btn;
        i_btn_raw[2] = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        n_checks++;
        if (o_io_btn !== 4'b0100) $display("FAIL release_setup: got %b want 0100", o_io_btn);
        else n_pass++;
        i_btn_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_btn = (k >= 6) ? 4'b0000 : 4'b0100;
            n_checks++;
            if (o_io_btn !== exp_btn || o_btn_press !== 4'h0)
                $display("FAIL release k=%0d: btn=%b press=%b want %b/0000", k, o_io_btn, o_btn_press, exp_btn);
            else n_pass++;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_press;
        i_btn_raw = 4'b0110;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_press = (k == 6) ? 4'b1001 : 4'b0000;
            n_checks++;
            if (o_btn_press !== exp_press) $display("FAIL simul_press k=%0d: got %b want %b", k, o_btn_press, exp_press);
            else n_pass++;
        end
        n_checks++;
        if (o_io_btn !== 4'b1001) $display("FAIL simul_btn: got %b want 1001", o_io_btn);
        else n_pass++;
        i_btn_raw = 4'hF;
        settle();
    endtask

    task automatic test_switches();
        logic [31:0] exp_sw;
        i_sw_raw = 32'hDEADBEEF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_sw = (k >= SW_LAT) ? 32'hDEADBEEF : 32'h0;
            n_checks++;
            if (o_io_sw !== exp_sw) $display("FAIL sw_value k=%0d: got %h want %h", k, o_io_sw, exp_sw);
            else n_pass++;
        end
        i_sw_raw = 32'h0;
        settle();
        i_sw_raw = 32'h1;
        tick();
        i_sw_raw = 32'h0;
        for (int k = 1; k <= 7; k++) begin
            exp_sw = (SW_LAT == 2 && k == 2) ? 32'h1 : 32'h0;
            n_checks++;
            if (o_io_sw !== exp_sw) $display("FAIL sw_pulse k=%0d: got %h want %h", k, o_io_sw, exp_sw);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_btn, exp_press;
        i_btn_raw[0] = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_io_btn !== 4'h0 || o_btn_press !== 4'h0 || o_io_sw !== 32'h0)
            $display("FAIL rstmid_async: btn=%b press=%b sw=%h want all 0", o_io_btn, o_btn_press, o_io_sw);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (o_io_btn !== 4'h0 || o_btn_press !== 4'h0)
            $display("FAIL rstmid_held: btn=%b press=%b want 0/0", o_io_btn, o_btn_press);
        else n_pass++;
        i_rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_btn   = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_press = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (o_io_btn !== exp_btn || o_btn_press !== exp_press)
                $display("FAIL rstmid_redetect k=%0d: btn=%b press=%b want %b/%b",
                         k, o_io_btn, o_btn_press, exp_btn, exp_press);
            else n_pass++;
        end
        i_btn_raw = 4'hF;
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_switches();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
